des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Iterative DES key-schedule engine.
- Accepts a 64-bit key and produces the sixteen 48-bit round subkeys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Feeds the round-key XOR that sits directly downstream of the expansion E-box, so its subkey output is bit-aligned with the 48-bit expansion output.
- One round engine consumes one subkey per round.

Parameters:
- None. The PC-1/PC-2 tables and shift schedule are fixed per FIPS 46-3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  key/decrypt present.
- key_ready  out  1  engine idle, can accept a key.
- key  in  64  DES key, indexed key[64:1]; key[n] = FIPS key bit n (bit 1 = leftmost in FIPS hex). Parity bits 8, 16, ..., 64 are ignored.
- decrypt  in  1  sampled with key: 0 = K1..K16, 1 = K16..K1.
- subkey_valid  out  1  subkey holds a valid round key.
- subkey_ready  in  1  downstream consumes the subkey.
- subkey  out  48  round key, subkey[47:0]; subkey[47] = PC-2 output bit 1, matching expansion output bit 47 = E bit 1.
- round  out  4  index of the presented subkey, 0..15 = rounds 1..16 in delivery order.
- last  out  1  high with the 16th subkey.

Behaviour:
- Reset, asynchronous, any time including mid-schedule:
  - State goes to IDLE.
  - C and D are cleared to 0.
  - subkey = 0, round = 0, subkey_valid = 0, last = 0.
  - key_ready = 1 after rst deasserts.
- States:
  - IDLE: key_ready = 1, subkey_valid = 0.
  - RUN: key_ready = 0, subkey_valid = 1.
- Key acceptance:
  - Key is accepted on the edge where key_valid & key_ready.
  - C0/D0 = PC-1(key) (28 bits each). decrypt is latched.
  - First subkey is registered and presented the following cycle: latency 1.
- Shift schedule (left rotates for encrypt, rounds 1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt round i: C_i,D_i = rotl(C_{i-1},D_{i-1}, s_i); subkey = PC-2(C_i,D_i).
  - Decrypt delivery step j (1..16): first step uses C0,D0 unrotated, since C16 = C0. Subsequent steps rotate right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - subkey is always PC-2 of the register contents after that step's rotate.
- Output handshake:
  - subkey, round and last are held stable while subkey_valid & !subkey_ready.
  - On subkey_valid & subkey_ready with round < 15: next subkey appears the next cycle and round increments by 1.
  - On acceptance with round = 15 (last = 1): return to IDLE next cycle. subkey_valid and last drop to 0; subkey holds its last value; key_ready = 1.
- Throughput: one subkey per cycle with subkey_ready tied high, so a full schedule takes 16 cycles.
- Back-to-back keys: a new key can be accepted only in IDLE. The earliest acceptance is the cycle after round 16 is consumed, giving 17 cycles per key.
- Keys are never dropped, and there are no partial schedules except by rst.
- key_valid while busy: ignored, since key_ready = 0. The upstream block holds its key.
- round wrap: round never exceeds 15; the counter is reset to 0 on key acceptance.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Encrypt, FIPS key 133457799BBCDFF1, decrypt = 0, subkey_ready = 1:
   - Key accepted at T; at T+1 subkey = 1B02EFFC7072, round = 0.
   - At T+2 subkey = 79AED9DBC9E5.
   - At T+16 subkey = CB3D8B0E17F5, last = 1.
   - At T+17 subkey_valid = 0, key_ready = 1.
2. Decrypt, same key: first subkey = CB3D8B0E17F5 (round = 0), second = K15, 16th = 1B02EFFC7072 with last = 1. The full sequence is the exact reverse of scenario 1.
3. Backpressure:
   - Toggle subkey_ready pseudo-randomly, including 10-cycle stalls.
   - subkey/round are stable during stalls; exactly 16 accepted subkeys equal scenario 1 in order.
   - key_valid held high throughout is not accepted until the cycle after the last handshake.
4. Reset mid-operation:
   - Assert rst asynchronously (between edges) after round 5 is presented.
   - subkey_valid = 0, subkey = 0 immediately.
   - After release, key_ready = 1; a new key 0E329232EA6D0D73 produces a correct 16-key schedule (compare with reference model).
5. Parity insensitivity: key 133457799BBCDFF1 with all parity bits inverted (bits 8, 16, ..., 64 flipped) yields subkeys identical to scenario 1.
6. Back-to-back keys: second key presented continuously. It is accepted the cycle key_ready rises after the first schedule; total 34 cycles for two schedules with subkey_ready = 1. Both sequences match the model.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on key load, then one C/D rotate plus PC-2 per
// delivered subkey, in encrypt order (K1..K16) or decrypt order (K16..K1).
//
// state | meaning
// IDLE  | no schedule active, key_ready_o high, waiting for key_valid_i
// RUN   | subkey_o/round_o presented, advances on subkey_ready_i
module des_key_schedule (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [47:0] subkey_o,
  output logic [3:0]  round_o,
  output logic        last_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // key_i[63] is FIPS key bit 1, so FIPS bit n lives at key_i[64-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  // cd[55] is C bit 1; result bit 47 is PC-2 output bit 1.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  // Schedule index 0..15 (round 1..16): rounds 1, 2, 9 and 16 shift by one.
  function automatic logic shift_two(input logic [3:0] idx);
    return !((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15));
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_half_q, c_half_d;
  logic [27:0] d_half_q, d_half_d;
  logic        dec_q, dec_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_q, round_d;
  logic        last_q, last_d;

  logic [55:0] cd0;
  logic [27:0] c_nxt, d_nxt;
  logic [3:0]  rnd_inc;
  logic        two;
  logic        load;

  logic        unused_parity;
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8], key_i[0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      c_half_q <= '0;
      d_half_q <= '0;
      dec_q    <= 1'b0;
      subkey_q <= '0;
      round_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      dec_q    <= dec_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    dec_d    = dec_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    last_d   = last_q;
    cd0      = pc1(key_i);
    rnd_inc  = round_q + 4'd1;
    c_nxt    = c_half_q;
    d_nxt    = d_half_q;
    two      = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          state_d = RUN;
          dec_d   = decrypt_i;
          round_d = '0;
          last_d  = 1'b0;
          load    = 1'b1;
          // Decrypt starts from C0/D0 as-is because C16/D16 equal C0/D0.
          if (decrypt_i) begin
            c_nxt = cd0[55:28];
            d_nxt = cd0[27:0];
          end else begin
            c_nxt = rotl(cd0[55:28], 1'b0);
            d_nxt = rotl(cd0[27:0], 1'b0);
          end
        end
      end
      RUN: begin
        if (subkey_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            load    = 1'b1;
            round_d = rnd_inc;
            last_d  = (rnd_inc == 4'd15);
            // Decrypt step r undoes encrypt round 17-r, i.e. schedule index 16-r.
            if (dec_q) begin
              two   = shift_two(4'd0 - rnd_inc);
              c_nxt = rotr(c_half_q, two);
              d_nxt = rotr(d_half_q, two);
            end else begin
              two   = shift_two(rnd_inc);
              c_nxt = rotl(c_half_q, two);
              d_nxt = rotl(d_half_q, two);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      c_half_d = c_nxt;
      d_half_d = d_nxt;
      subkey_d = pc2({c_nxt, d_nxt});
    end
  end

  assign key_ready_o    = (state_q == IDLE);
  assign subkey_valid_o = (state_q == RUN);
  assign subkey_o       = subkey_q;
  assign round_o        = round_q;
  assign last_o         = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: spec vectors, backpressure, reset, back-to-back and
// random keys against a cumulative-rotation reference model.
module tb_des_key_schedule;

  logic        clk_i;
  logic        rst_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [63:0] key_i;
  logic        decrypt_i;
  logic        subkey_valid_o;
  logic        subkey_ready_i;
  logic [47:0] subkey_o;
  logic [3:0]  round_o;
  logic        last_o;

  des_key_schedule dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .key_valid_i    (key_valid_i),
    .key_ready_o    (key_ready_o),
    .key_i          (key_i),
    .decrypt_i      (decrypt_i),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .subkey_o       (subkey_o),
    .round_o        (round_o),
    .last_o         (last_o)
  );

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TB_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          idx;
    logic [47:0] expv;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          rand_mode = 0;
  logic        ready_fixed = 1'b1;
  int          stall_left = 0;
  logic [47:0] hs_key [$];
  logic [3:0]  hs_rnd [$];
  logic        hs_last [$];
  int          hs_cyc [$];
  int          acc_cyc [$];
  logic [47:0] exp_ks [16];
  vec_t        vecs [8];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, expv);
    end
  endtask

  function automatic logic [47:0] hs_at(input int i);
    return (i < hs_key.size()) ? hs_key[i] : 48'hx;
  endfunction
  function automatic logic [3:0] rnd_at(input int i);
    return (i < hs_rnd.size()) ? hs_rnd[i] : 4'hx;
  endfunction
  function automatic logic last_at(input int i);
    return (i < hs_last.size()) ? hs_last[i] : 1'bx;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1;
  endfunction
  function automatic int last_acc();
    return (acc_cyc.size() > 0) ? acc_cyc[$] : -1;
  endfunction

  // Subkey i = PC-2 of C0/D0 rotated left by the running total of shifts;
  // decrypt order is the encrypt list read backwards.
  task automatic ref_sched(input logic [63:0] k, input logic dec);
    bit          c0 [28];
    bit          d0 [28];
    logic [47:0] enc [16];
    int          tot;
    tot = 0;
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64-TB_PC1[i]];
      d0[i] = k[64-TB_PC1[28+i]];
    end
    for (int r = 0; r < 16; r++) begin
      tot += TB_SHIFT[r];
      enc[r] = '0;
      for (int m = 0; m < 48; m++) begin
        int p;
        p = TB_PC2[m] - 1;
        enc[r][47-m] = (p < 28) ? c0[(p + tot) % 28] : d0[(p - 28 + tot) % 28];
      end
    end
    for (int r = 0; r < 16; r++) exp_ks[r] = dec ? enc[15-r] : enc[r];
  endtask

  // Ready generator: fixed level, or random with occasional 10-cycle stalls.
  initial begin
    subkey_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_mode) begin
        if (stall_left > 0) begin
          subkey_ready_i = 1'b0;
          stall_left--;
        end else if ($urandom_range(0, 15) == 0) begin
          subkey_ready_i = 1'b0;
          stall_left = 9;
        end else begin
          subkey_ready_i = ($urandom_range(0, 2) != 0);
        end
      end else begin
        subkey_ready_i = ready_fixed;
      end
    end
  end

  // Handshake/accept recorder and stall-stability checker; records at the
  // negedge preceding the edge on which the transfer happens.
  initial begin
    logic        stall_prev;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic        prev_last;
    stall_prev = 1'b0;
    prev_sk    = '0;
    prev_rnd   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall valid", 64'(subkey_valid_o), 64'd1);
          chk("stall subkey", 64'(subkey_o), 64'(prev_sk));
          chk("stall round", 64'(round_o), 64'(prev_rnd));
          chk("stall last", 64'(last_o), 64'(prev_last));
        end
        if (subkey_valid_o && subkey_ready_i) begin
          hs_key.push_back(subkey_o);
          hs_rnd.push_back(round_o);
          hs_last.push_back(last_o);
          hs_cyc.push_back(cyc + 1);
        end
        if (key_valid_i && key_ready_o) acc_cyc.push_back(cyc + 1);
        stall_prev = subkey_valid_o && !subkey_ready_i;
        prev_sk    = subkey_o;
        prev_rnd   = round_o;
        prev_last  = last_o;
      end
    end
  end

  task automatic present_key(input logic [63:0] k, input logic dec);
    int n0;
    int b;
    n0 = acc_cyc.size();
    b = 0;
    key_i = k;
    decrypt_i = dec;
    key_valid_i = 1'b1;
    while (acc_cyc.size() == n0 && b < 300) begin
      @(posedge clk_i);
      #1;
      b++;
    end
    chk("key accepted", 64'(acc_cyc.size() > n0), 64'd1);
    key_valid_i = 1'b0;
  endtask

  task automatic wait_acc(input int n0, input string nm);
    int b;
    b = 0;
    while (acc_cyc.size() == n0 && b < 300) begin
      @(posedge clk_i);
      #1;
      b++;
    end
    chk({nm, " accept seen"}, 64'(acc_cyc.size() > n0), 64'd1);
  endtask

  task automatic wait_hs(input int target, input string nm);
    int b;
    b = 0;
    while (hs_key.size() < target && b < 2000) begin
      @(posedge clk_i);
      #1;
      b++;
    end
    chk({nm, " handshakes done"}, 64'(hs_key.size() >= target), 64'd1);
  endtask

  task automatic check_sched(input int base, input string nm);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s subkey[%0d]", nm, i), 64'(hs_at(base + i)), 64'(exp_ks[i]));
      chk($sformatf("%s round[%0d]", nm, i), 64'(rnd_at(base + i)), 64'(i));
      chk($sformatf("%s last[%0d]", nm, i), 64'(last_at(base + i)), 64'(i == 15));
    end
  endtask

  task automatic run_one(input logic [63:0] k, input logic dec, input bit chk_lat, input string nm);
    int base;
    int a;
    base = hs_key.size();
    ref_sched(k, dec);
    present_key(k, dec);
    a = last_acc();
    wait_hs(base + 16, nm);
    check_sched(base, nm);
    if (chk_lat) begin
      chk({nm, " first hs cycle"}, 64'(cyc_at(base)), 64'(a + 1));
      chk({nm, " last hs cycle"}, 64'(cyc_at(base + 15)), 64'(a + 16));
    end
    chk({nm, " idle key_ready"}, 64'(key_ready_o), 64'd1);
    chk({nm, " idle valid"}, 64'(subkey_valid_o), 64'd0);
    chk({nm, " idle last"}, 64'(last_o), 64'd0);
    chk({nm, " idle subkey held"}, 64'(subkey_o), 64'(exp_ks[15]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a1;
    int a2;
    int n1;
    int hs_end;
    logic [63:0] rk;
    logic        rd;

    vecs[0] = '{KEY_A,          1'b0,  0, 48'h1B02EFFC7072};
    vecs[1] = '{KEY_A,          1'b0,  1, 48'h79AED9DBC9E5};
    vecs[2] = '{KEY_A,          1'b0, 15, 48'hCB3D8B0E17F5};
    vecs[3] = '{KEY_A,          1'b1,  0, 48'hCB3D8B0E17F5};
    vecs[4] = '{KEY_A,          1'b1, 14, 48'h79AED9DBC9E5};
    vecs[5] = '{KEY_A,          1'b1, 15, 48'h1B02EFFC7072};
    vecs[6] = '{KEY_A ^ PARITY, 1'b0,  0, 48'h1B02EFFC7072};
    vecs[7] = '{KEY_A ^ PARITY, 1'b0, 15, 48'hCB3D8B0E17F5};

    rst_i = 1'b1;
    key_valid_i = 1'b0;
    key_i = '0;
    decrypt_i = 1'b0;

    #12;
    chk("reset valid", 64'(subkey_valid_o), 64'd0);
    chk("reset subkey", 64'(subkey_o), 64'd0);
    chk("reset round", 64'(round_o), 64'd0);
    chk("reset last", 64'(last_o), 64'd0);
    #5;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("post-reset key_ready", 64'(key_ready_o), 64'd1);

    for (int v = 0; v < 8; v++) begin
      base = hs_key.size();
      run_one(vecs[v].key, vecs[v].dec, (v == 0), $sformatf("vec%0d", v));
      chk($sformatf("vec%0d fips value", v), 64'(hs_at(base + vecs[v].idx)), 64'(vecs[v].expv));
    end

    // Backpressure with a second key held valid the whole time.
    stall_left = 10;
    rand_mode = 1;
    base = hs_key.size();
    ref_sched(KEY_A, 1'b0);
    present_key(KEY_A, 1'b0);
    key_i = KEY_B;
    decrypt_i = 1'b0;
    key_valid_i = 1'b1;
    n1 = acc_cyc.size();
    wait_hs(base + 16, "bp");
    check_sched(base, "bp");
    hs_end = cyc_at(base + 15);
    wait_acc(n1, "bp held");
    chk("bp held key accept cycle", 64'(last_acc()), 64'(hs_end + 1));
    chk("bp no extra handshakes", 64'(hs_key.size()), 64'(base + 16));
    key_valid_i = 1'b0;
    rand_mode = 0;
    ref_sched(KEY_B, 1'b0);
    wait_hs(base + 32, "bp second");
    check_sched(base + 16, "bp second");

    // Asynchronous reset while round 5 is presented.
    base = hs_key.size();
    key_i = KEY_A;
    decrypt_i = 1'b0;
    key_valid_i = 1'b1;
    n1 = acc_cyc.size();
    wait_acc(n1, "rst");
    key_valid_i = 1'b0;
    a1 = 0;
    while (round_o != 4'd5 && a1 < 40) begin
      @(posedge clk_i);
      #1;
      a1++;
    end
    chk("rst reached round 5", 64'(round_o), 64'd5);
    #3;
    rst_i = 1'b1;
    #1;
    chk("rst valid", 64'(subkey_valid_o), 64'd0);
    chk("rst subkey", 64'(subkey_o), 64'd0);
    chk("rst round", 64'(round_o), 64'd0);
    chk("rst last", 64'(last_o), 64'd0);
    hs_key.delete();
    hs_rnd.delete();
    hs_last.delete();
    hs_cyc.delete();
    acc_cyc.delete();
    #2;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst release key_ready", 64'(key_ready_o), 64'd1);
    chk("rst release valid", 64'(subkey_valid_o), 64'd0);
    run_one(KEY_B, 1'b0, 1'b1, "after rst");

    // Back-to-back keys with subkey_ready tied high.
    base = hs_key.size();
    ref_sched(KEY_A, 1'b0);
    present_key(KEY_A, 1'b0);
    a1 = last_acc();
    n1 = acc_cyc.size();
    key_i = KEY_B;
    decrypt_i = 1'b1;
    key_valid_i = 1'b1;
    wait_acc(n1, "b2b");
    key_valid_i = 1'b0;
    a2 = last_acc();
    chk("b2b second accept cycle", 64'(a2), 64'(a1 + 17));
    wait_hs(base + 32, "b2b");
    check_sched(base, "b2b first");
    ref_sched(KEY_B, 1'b1);
    check_sched(base + 16, "b2b second");
    chk("b2b total cycles", 64'(cyc_at(base + 31) + 1 - a1), 64'd34);
    chk("b2b idle key_ready", 64'(key_ready_o), 64'd1);

    // Random keys and directions under random backpressure.
    rand_mode = 1;
    for (int t = 0; t < 5; t++) begin
      rk = {$urandom(), $urandom()};
      rd = 1'($urandom_range(0, 1));
      run_one(rk, rd, 1'b0, $sformatf("rand%0d", t));
    end
    rand_mode = 0;

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
